// File: rtl/fsk_phase_ctrl.sv
// rtl/fsk_phase_ctrl.sv - phase-continuous FSK phase accumulator driving a sine ROM address
module fsk_phase_ctrl #(
    parameter int          ADDR_W          = 10,
    parameter int          ACC_W           = 24,
    parameter logic [23:0] TW0             = 24'h004000,
    parameter logic [23:0] TW1             = 24'h008000,
    parameter int          SAMPLES_PER_BIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              addr_valid,
    output logic              cur_bit,
    output logic              underrun
);

    // A counter of at least one bit keeps SAMPLES_PER_BIT == 1 legal.
    localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_BIT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  tw;
    logic              accept;
    logic              last_sample;

    assign last_sample = (state == SEND) && (cnt == '0);
    assign bit_ready   = !rst && ((state == IDLE) || last_sample);
    assign accept      = bit_valid && bit_ready;
    assign tw          = cur_bit ? ACC_W'(TW1) : ACC_W'(TW0);
    assign rom_addr    = acc[ACC_W-1 -: ADDR_W];
    assign addr_valid  = (state == SEND);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = SEND;
            SEND: if (last_sample && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase is never reset at symbol boundaries, so the tone stays continuous.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            cur_bit  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= last_sample && !accept;
            if (state == SEND) begin
                acc <= acc + tw;
            end
            if (accept) begin
                cur_bit <= bit_in;
                cnt     <= CNT_LAST;
            end else if ((state == SEND) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsk_phase_ctrl.sv
// tb/tb_fsk_phase_ctrl.sv - directed vector bench for fsk_phase_ctrl
module tb_fsk_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst, bit_in, bit_valid;
    logic       bit_ready, addr_valid, cur_bit, underrun;
    logic [9:0] rom_addr;

    logic       w_rst, w_bit_in, w_bit_valid;
    logic       w_bit_ready, w_addr_valid, w_cur_bit, w_underrun;
    logic [9:0] w_rom_addr;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fsk_phase_ctrl #(
        .ADDR_W(10), .ACC_W(24), .TW0(24'h004000), .TW1(24'h008000), .SAMPLES_PER_BIT(4)
    ) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .rom_addr(rom_addr), .addr_valid(addr_valid),
        .cur_bit(cur_bit), .underrun(underrun)
    );

    fsk_phase_ctrl #(
        .ADDR_W(10), .ACC_W(24), .TW0(24'h004000), .TW1(24'h800000), .SAMPLES_PER_BIT(4)
    ) dut_wrap (
        .clk(clk), .rst(w_rst), .bit_in(w_bit_in), .bit_valid(w_bit_valid),
        .bit_ready(w_bit_ready), .rom_addr(w_rom_addr), .addr_valid(w_addr_valid),
        .cur_bit(w_cur_bit), .underrun(w_underrun)
    );

    typedef struct {
        logic       rst;
        logic       bin;
        logic       bval;
        logic [9:0] addr;
        logic       val;
        logic       rdy;
        logic       cur;
        logic       und;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic b, input logic v, input int a,
                       input logic ev, input logic er, input logic ec, input logic eu);
        vec_t t;
        t.rst = r; t.bin = b; t.bval = v; t.addr = 10'(a);
        t.val = ev; t.rdy = er; t.cur = ec; t.und = eu;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got addr=%0d val=%b rdy=%b cur=%b und=%b, want addr=%0d val=%b rdy=%b cur=%b und=%b",
                     name, act[13:4], act[3], act[2], act[1], act[0],
                     exp[13:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        //   rst bin val addr val rdy cur und
        add(1, 0, 0,  0, 0, 0, 0, 0);
        add(1, 0, 0,  0, 0, 0, 0, 0);
        add(1, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 0, 1, 0, 0);   // accept bit 0
        add(0, 1, 1,  0, 1, 0, 0, 0);
        add(0, 1, 1,  1, 1, 0, 0, 0);
        add(0, 1, 1,  2, 1, 0, 0, 0);
        add(0, 1, 1,  3, 1, 1, 0, 0);   // back-to-back accept of bit 1
        add(0, 1, 0,  4, 1, 0, 1, 0);
        add(0, 1, 0,  6, 1, 0, 1, 0);
        add(0, 1, 0,  8, 1, 0, 1, 0);
        add(0, 1, 0, 10, 1, 1, 1, 0);
        add(0, 0, 0, 12, 0, 1, 1, 1);   // underrun pulse
        add(0, 0, 0, 12, 0, 1, 1, 0);
        add(0, 0, 0, 12, 0, 1, 1, 0);
        add(0, 0, 0, 12, 0, 1, 1, 0);
        add(0, 0, 1, 12, 0, 1, 1, 0);   // 5th idle cycle: accept bit 0
        add(0, 1, 1, 12, 1, 0, 0, 0);   // bit_valid toggles while not ready
        add(0, 1, 0, 13, 1, 0, 0, 0);
        add(0, 1, 1, 14, 1, 0, 0, 0);
        add(0, 1, 1, 15, 1, 1, 0, 0);   // taken only on the last sample
        add(0, 1, 0, 16, 1, 0, 1, 0);
        add(0, 1, 0, 18, 1, 0, 1, 0);
        add(1, 1, 0, 20, 1, 0, 1, 0);   // reset on sample 2
        add(0, 1, 1,  0, 0, 1, 0, 0);
        add(0, 0, 0,  0, 1, 0, 1, 0);
        add(0, 0, 0,  2, 1, 0, 1, 0);
        add(0, 0, 0,  4, 1, 0, 1, 0);
        add(0, 0, 0,  6, 1, 1, 1, 0);
        add(0, 0, 0,  8, 0, 1, 1, 1);

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
        w_rst = 1'b1; w_bit_in = 1'b0; w_bit_valid = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; bit_in = vecs[i].bin; bit_valid = vecs[i].bval;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {rom_addr, addr_valid, bit_ready, cur_bit, underrun},
                  {vecs[i].addr, vecs[i].val, vecs[i].rdy, vecs[i].cur, vecs[i].und});
            @(posedge clk); #1;
        end

        // Accumulator wrap: step of 512 addresses, bit 1 sent twice back-to-back.
        w_rst = 1'b0; w_bit_in = 1'b1; w_bit_valid = 1'b1;
        @(negedge clk);
        check("wrap_idle", {w_rom_addr, w_addr_valid, w_bit_ready, w_cur_bit, w_underrun},
              {10'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 4) w_bit_valid = 1'b0;
            @(negedge clk);
            check($sformatf("wrap_s%0d", k),
                  {w_rom_addr, w_addr_valid, w_bit_ready, w_cur_bit, w_underrun},
                  {((k % 2) == 1) ? 10'd512 : 10'd0, 1'b1, (k == 3 || k == 7), 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("wrap_end", {w_rom_addr, w_addr_valid, w_bit_ready, w_cur_bit, w_underrun},
              {10'd0, 1'b0, 1'b1, 1'b1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
